wb_retire_queue: RTL and testbench
==================================

// Module: wb_retire_queue
// PURPOSE
//  Parametrised writeback stage and the successor to the single-cycle writeback mux.
//  - Result select: ALU data, memory output, PC+2, or zero-extended condition bit.
//  - Queues selected results in a DEPTH-entry buffer, so the register-file write port can stall.
//  - Sits between the MEM/WB pipeline register and the register-file write port.
//  - Counts retired instructions.
// PARAMETERS
//  DATA_W     16  datapath width (result, PC, memory, ALU)
//  REG_ADDR_W  3  register-file address width
//  DEPTH       2  buffer entries, >=1, power of two not required
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           reset: one clock; reset is asynchronous and active-low
//  in_valid     in   1           retiring instruction present
//  in_ready     out  1           stage can accept this cycle
//  in_sel       in   2           result source: 00 ALU, 01 MEM, 10 PC, 11 COND
//  in_pcinc     in   DATA_W      PC+2 of instruction
//  in_memout    in   DATA_W      load data
//  in_data      in   DATA_W      ALU result
//  in_cond      in   1           set-condition result
//  in_wr_en     in   1           instruction writes a register
//  in_wr_addr   in   REG_ADDR_W  destination register
//  rf_valid     out  1           write pending at head
//  rf_ready     in   1           register file accepts write
//  rf_wr_addr   out  REG_ADDR_W  head destination
//  rf_wr_data   out  DATA_W      head result
//  retire_cnt   out  16          retired-instruction count
// BEHAVIOUR
//  - Reset (async assert, sync release): buffer empty, pointers 0, retire_cnt 0.
//    While in reset: rf_valid=0, rf_wr_addr=0, rf_wr_data=0, in_ready=0.
//    Reset asserted mid-operation discards all queued writes.
//  - in_ready = (count < DEPTH). It is registered-state only; it does not depend on rf_ready.
//    A full buffer with a simultaneous drain does not accept in that cycle.
//  - Accept = in_valid & in_ready. The result is selected at accept time:
//    COND result = {DATA_W-1 zeros, in_cond}.
//  - Accept with in_wr_en=1: the entry is enqueued at wptr.
//  - Accept with in_wr_en=0 (stores, branches): nothing is enqueued, but the instruction still retires.
//  - retire_cnt increments by 1 on every accept and wraps 16'hFFFF -> 0.
//  - Drain = rf_valid & rf_ready. rf_valid = (count != 0). rf_wr_* reflect the head entry.
//  - Enqueue and drain in the same cycle: count is unchanged, both pointers advance.
//  - Latency: an accepted write appears on rf_* the next cycle when the buffer was empty.
//    It is never presented combinationally in the accept cycle.
//  - Pointers wrap DEPTH-1 -> 0. count ranges 0..DEPTH.
//  - Order: register writes reach rf_* strictly in accept order.
//  - Holding rule: while rf_valid=1 and rf_ready=0, rf_wr_addr and rf_wr_data stay stable.
// CONFIGURATION
//  WB_FWD_EN defined:
//   - Adds ports fwd_addr (in, REG_ADDR_W), fwd_hit (out, 1), fwd_data (out, DATA_W).
//   - fwd_hit=1 when any queued entry targets fwd_addr. fwd_data is from the youngest such entry.
//   - The lookup is combinational over buffered entries only; the in_* port is not included.
//  WB_FWD_EN undefined: the ports are absent and no comparators are built.
// STRUCTURE
//  - Package wb_pkg:
//    - Select constants WB_SEL_ALU/MEM/PC/COND.
//    - Entry struct {addr, data}.
//    - Function wb_select(sel, pcinc, memout, data, cond).
//  - Sub-module wb_fifo: DEPTH-entry circular buffer with pointer and count logic.
//    It exposes its entry array for the forwarding search.
//  - Top level: select logic, retire counter, forwarding search.
// TESTING
//  1. Reset mid-stream with 2 entries queued -> rf_valid=0, retire_cnt=0, in_ready=1 one cycle after release.
//  2. sel=10, pcinc=16'h0042, wr_addr=5, rf_ready=1 -> next cycle rf_valid=1, addr 5, data 16'h0042.
//  3. sel=11, cond=1, data=16'hFFFF -> rf_wr_data=16'h0001; with sel=00 instead, rf_wr_data=16'hFFFF.
//  4. rf_ready=0, 3 writes offered, DEPTH=2 -> 2 accepted, in_ready=0.
//     Then rf_ready=1 -> drain in order, third write accepted when count<2.
//  5. in_wr_en=0 for 4 accepts -> rf_valid stays 0, retire_cnt=4. Preload retire_cnt 16'hFFFF + 1 accept -> 0.
//  6. WB_FWD_EN, entries to r3=16'h0011 then r3=16'h0022, fwd_addr=3 -> fwd_hit=1, fwd_data=16'h0022.

Source files
------------

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback retire queue:
//   - wb_sel_e      : result-source encoding (ALU, MEM, PC, COND)
//   - wb_entry_t    : one queued register write {addr, data}
//   - wb_select()   : result multiplexer applied at accept time
// The struct and the select function are sized by WB_DATA_W / WB_REG_ADDR_W;
// wb_retire_queue takes its width parameters from these values by default
// and they must be kept equal.
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DATA_W     = 16;
    localparam int WB_REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_PC   = 2'b10,
        WB_SEL_COND = 2'b11
    } wb_sel_e;

    typedef struct packed {
        logic [WB_REG_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]     data;
    } wb_entry_t;

    // Condition results are zero-extended so a set-condition writes 0 or 1.
    function automatic logic [WB_DATA_W-1:0] wb_select(
        input logic [1:0]           sel,
        input logic [WB_DATA_W-1:0] pcinc,
        input logic [WB_DATA_W-1:0] memout,
        input logic [WB_DATA_W-1:0] data,
        input logic                 cond
    );
        logic [WB_DATA_W-1:0] result;
        case (wb_sel_e'(sel))
            WB_SEL_ALU:  result = data;
            WB_SEL_MEM:  result = memout;
            WB_SEL_PC:   result = pcinc;
            WB_SEL_COND: result = {{(WB_DATA_W-1){1'b0}}, cond};
            default:     result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry circular buffer of pending register-file writes.
// DEPTH need not be a power of two; pointers wrap DEPTH-1 -> 0 explicitly.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_addr/data  enqueue request (ignored when full)
//   pop                   dequeue request (ignored when empty)
//   full_n                registered "count < DEPTH"; 0 while in reset
//   nonempty              registered "count != 0"
//   head_addr/head_data   oldest entry, straight from storage flops
//   rd_ptr, fill,         (only when WB_FWD_EN is defined) read pointer,
//   entry_addr/entry_data  occupancy and raw storage for the forwarding search
// ---------------------------------------------------------------------------
module wb_fifo #(
    parameter  int DEPTH  = 2,
    parameter  int ADDR_W = 3,
    parameter  int DATA_W = 16,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
`ifdef WB_FWD_EN
    output logic [PTR_W-1:0]  rd_ptr,
    output logic [CNT_W-1:0]  fill,
    output logic [ADDR_W-1:0] entry_addr [DEPTH],
    output logic [DATA_W-1:0] entry_data [DEPTH],
`endif
    output logic              full_n,
    output logic              nonempty,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              full_n_q, full_n_d;
    logic              nonempty_q, nonempty_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic              push_s;
    logic              pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Requests are qualified against the registered flags so a misbehaving
    // caller can never overflow or underflow the buffer.
    assign push_s = push & full_n_q;
    assign pop_s  = pop & nonempty_q;

    // Next-state for pointers, occupancy, status flags and entry storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        data_d   = data_q;

        if (push_s) begin
            wr_ptr_d         = ptr_inc(wr_ptr_q);
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_n_d   = (count_d < CNT_W'(DEPTH));
        nonempty_d = (count_d != {CNT_W{1'b0}});
    end

    // Control state; full_n resets low so the stage refuses input in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            full_n_q   <= 1'b0;
            nonempty_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_n_q   <= full_n_d;
            nonempty_q <= nonempty_d;
        end
    end

    // Entry storage; cleared in reset so the head outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= {ADDR_W{1'b0}};
                data_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full_n    = full_n_q;
    assign nonempty  = nonempty_q;
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

`ifdef WB_FWD_EN
    assign rd_ptr     = rd_ptr_q;
    assign fill       = count_q;
    assign entry_addr = addr_q;
    assign entry_data = data_q;
`endif

endmodule

// File: rtl/wb_retire_queue.sv
// ---------------------------------------------------------------------------
// wb_retire_queue
// Writeback stage between the MEM/WB pipeline register and the register-file
// write port. Selects the result at accept time, queues register writes in a
// DEPTH-entry buffer so the write port may stall, and counts retirements.
//
// Optional feature macro: WB_FWD_EN
//   defined   -> adds fwd_addr / fwd_hit / fwd_data: combinational lookup of
//                the youngest queued entry targeting fwd_addr (in_* excluded)
//   undefined -> those ports and their comparators are absent
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid / in_ready           retiring instruction handshake
//   in_sel                        00 ALU, 01 MEM, 10 PC+2, 11 condition bit
//   in_pcinc, in_memout, in_data  candidate results
//   in_cond                       set-condition result
//   in_wr_en, in_wr_addr          register write request and destination
//   rf_valid / rf_ready           register-file write handshake
//   rf_wr_addr, rf_wr_data        head-of-queue write
//   retire_cnt                    16-bit wrapping retired-instruction count
// ---------------------------------------------------------------------------
module wb_retire_queue
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int REG_ADDR_W = WB_REG_ADDR_W,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_sel,
    input  logic [DATA_W-1:0]     in_pcinc,
    input  logic [DATA_W-1:0]     in_memout,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_cond,
    input  logic                  in_wr_en,
    input  logic [REG_ADDR_W-1:0] in_wr_addr,
`ifdef WB_FWD_EN
    input  logic [REG_ADDR_W-1:0] fwd_addr,
    output logic                  fwd_hit,
    output logic [DATA_W-1:0]     fwd_data,
`endif
    output logic                  rf_valid,
    input  logic                  rf_ready,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0]     rf_wr_data,
    output logic [15:0]           retire_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic      accept_s;
    logic      push_s;
    logic      pop_s;
    wb_entry_t push_entry_s;
    logic [15:0] retire_cnt_q, retire_cnt_d;

`ifdef WB_FWD_EN
    logic [PTR_W-1:0]      fifo_rd_ptr_s;
    logic [CNT_W-1:0]      fifo_fill_s;
    logic [REG_ADDR_W-1:0] fifo_entry_addr_s [DEPTH];
    logic [DATA_W-1:0]     fifo_entry_data_s [DEPTH];
    logic [PTR_W-1:0]      fwd_idx_s;
    logic                  fwd_hit_s;
    logic [DATA_W-1:0]     fwd_data_s;
`endif

    // in_ready is a registered flag inside the buffer, so accepting never
    // depends on rf_ready in the same cycle.
    assign accept_s = in_valid & in_ready;
    // Stores and branches retire without occupying a buffer entry.
    assign push_s   = accept_s & in_wr_en;
    assign pop_s    = rf_valid & rf_ready;

    // Result is captured at accept time; later input changes do not matter.
    always_comb begin
        push_entry_s.addr = in_wr_addr;
        push_entry_s.data = wb_select(in_sel, in_pcinc, in_memout, in_data, in_cond);
    end

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (REG_ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_addr  (push_entry_s.addr),
        .push_data  (push_entry_s.data),
        .pop        (pop_s),
`ifdef WB_FWD_EN
        .rd_ptr     (fifo_rd_ptr_s),
        .fill       (fifo_fill_s),
        .entry_addr (fifo_entry_addr_s),
        .entry_data (fifo_entry_data_s),
`endif
        .full_n     (in_ready),
        .nonempty   (rf_valid),
        .head_addr  (rf_wr_addr),
        .head_data  (rf_wr_data)
    );

    // Retire counter next state; 16-bit addition wraps FFFF -> 0 naturally.
    always_comb begin
        if (accept_s) begin
            retire_cnt_d = retire_cnt_q + 16'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= 16'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

`ifdef WB_FWD_EN
    // Physical slot of the entry 'offset' positions after the head.
    function automatic logic [PTR_W-1:0] ring_index(
        input logic [PTR_W-1:0] base,
        input int unsigned      offset
    );
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + (PTR_W+1)'(offset);
        if (sum >= (PTR_W+1)'(DEPTH)) begin
            sum = sum - (PTR_W+1)'(DEPTH);
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Walk occupied slots oldest to youngest; a later match overrides an
    // earlier one so the youngest write to fwd_addr wins.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DATA_W{1'b0}};
        fwd_idx_s  = {PTR_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx_s = ring_index(fifo_rd_ptr_s, k);
            if ((CNT_W'(k) < fifo_fill_s) &&
                (fifo_entry_addr_s[fwd_idx_s] == fwd_addr)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = fifo_entry_data_s[fwd_idx_s];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    assign fwd_hit  = fwd_hit_s;
    assign fwd_data = fwd_data_s;
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_retire_queue
// Directed bench for wb_retire_queue at default parameters (DATA_W=16,
// REG_ADDR_W=3, DEPTH=2). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
module tb_wb_retire_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [15:0] in_pcinc;
    logic [15:0] in_memout;
    logic [15:0] in_data;
    logic        in_cond;
    logic        in_wr_en;
    logic [2:0]  in_wr_addr;
    logic        rf_valid;
    logic        rf_ready;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic [15:0] retire_cnt;
`ifdef WB_FWD_EN
    logic [2:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    wb_retire_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_pcinc   (in_pcinc),
        .in_memout  (in_memout),
        .in_data    (in_data),
        .in_cond    (in_cond),
        .in_wr_en   (in_wr_en),
        .in_wr_addr (in_wr_addr),
`ifdef WB_FWD_EN
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
`endif
        .rf_valid   (rf_valid),
        .rf_ready   (rf_ready),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .retire_cnt (retire_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_sel     = 2'b00;
        in_pcinc   = 16'h0000;
        in_memout  = 16'h0000;
        in_data    = 16'h0000;
        in_cond    = 1'b0;
        in_wr_en   = 1'b0;
        in_wr_addr = 3'd0;
    endtask

    task automatic offer(input logic [1:0] sel, input logic [15:0] pcinc,
                         input logic [15:0] memout, input logic [15:0] data,
                         input logic cond, input logic wr_en, input logic [2:0] addr);
        in_valid   = 1'b1;
        in_sel     = sel;
        in_pcinc   = pcinc;
        in_memout  = memout;
        in_data    = data;
        in_cond    = cond;
        in_wr_en   = wr_en;
        in_wr_addr = addr;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL rst_rf_valid: got %b want 0", rf_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (rf_wr_addr !== 3'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", rf_wr_addr); end
        checks++; if (rf_wr_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", rf_wr_data); end
        checks++; if (retire_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", retire_cnt); end
        #2 rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_early: got %b want 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
        exp_cnt = 16'd0;
    endtask

    task automatic test_no_write();
        rf_ready = 1'b0;
        offer(2'b00, 16'h0000, 16'h0000, 16'h1357, 1'b0, 1'b0, 3'd1);
        repeat (4) step();
        idle();
        exp_cnt = exp_cnt + 16'd4;
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL nowr_valid: got %b want 0", rf_valid); end
        checks++; if (retire_cnt !== 16'd4) begin errors++; $display("FAIL nowr_cnt: got %0d want 4", retire_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nowr_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_pc_select();
        rf_ready = 1'b1;
        offer(2'b10, 16'h0042, 16'h1234, 16'hABCD, 1'b0, 1'b1, 3'd5);
        #1;
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL pc_not_comb: got %b want 0", rf_valid); end
        step();
        idle();
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (rf_valid !== 1'b1) begin errors++; $display("FAIL pc_valid: got %b want 1", rf_valid); end
        checks++; if (rf_wr_addr !== 3'd5) begin errors++; $display("FAIL pc_addr: got %0d want 5", rf_wr_addr); end
        checks++; if (rf_wr_data !== 16'h0042) begin errors++; $display("FAIL pc_data: got %h want 0042", rf_wr_data); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL pc_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
        step();
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL pc_drained: got %b want 0", rf_valid); end
    endtask

    // COND then ALU then MEM back to back with rf_ready high: each cycle
    // drains the previous write while enqueuing the next.
    task automatic test_back_to_back();
        rf_ready = 1'b1;
        offer(2'b11, 16'h2222, 16'h3333, 16'hFFFF, 1'b1, 1'b1, 3'd2);
        step();
        checks++; if (rf_wr_data !== 16'h0001) begin errors++; $display("FAIL cond_data: got %h want 0001", rf_wr_data); end
        checks++; if (rf_wr_addr !== 3'd2) begin errors++; $display("FAIL cond_addr: got %0d want 2", rf_wr_addr); end
        offer(2'b00, 16'h2222, 16'h3333, 16'hFFFF, 1'b1, 1'b1, 3'd4);
        step();
        checks++; if (rf_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b want 1", rf_valid); end
        checks++; if (rf_wr_data !== 16'hFFFF) begin errors++; $display("FAIL alu_data: got %h want ffff", rf_wr_data); end
        checks++; if (rf_wr_addr !== 3'd4) begin errors++; $display("FAIL alu_addr: got %0d want 4", rf_wr_addr); end
        offer(2'b01, 16'h2222, 16'hBEEF, 16'hFFFF, 1'b1, 1'b1, 3'd7);
        step();
        idle();
        exp_cnt = exp_cnt + 16'd3;
        checks++; if (rf_wr_data !== 16'hBEEF) begin errors++; $display("FAIL mem_data: got %h want beef", rf_wr_data); end
        checks++; if (rf_wr_addr !== 3'd7) begin errors++; $display("FAIL mem_addr: got %0d want 7", rf_wr_addr); end
        step();
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", rf_valid); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        rf_ready = 1'b0;
        offer(2'b00, 16'h0000, 16'h0000, 16'h1111, 1'b0, 1'b1, 3'd1);
        step();
        offer(2'b00, 16'h0000, 16'h0000, 16'h2222, 1'b0, 1'b1, 3'd2);
        step();
        exp_cnt = exp_cnt + 16'd2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", in_ready); end
        offer(2'b00, 16'h0000, 16'h0000, 16'h3333, 1'b0, 1'b1, 3'd3);
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full: got %b want 0", in_ready); end
        checks++; if (rf_wr_data !== 16'h1111) begin errors++; $display("FAIL bp_hold_data: got %h want 1111", rf_wr_data); end
        checks++; if (rf_wr_addr !== 3'd1) begin errors++; $display("FAIL bp_hold_addr: got %0d want 1", rf_wr_addr); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL bp_no_accept: got %0d want %0d", retire_cnt, exp_cnt); end
        // Drain while full: the third write must still wait this cycle.
        rf_ready = 1'b1;
        step();
        checks++; if (rf_wr_data !== 16'h2222) begin errors++; $display("FAIL bp_order2: got %h want 2222", rf_wr_data); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL bp_full_drain: got %0d want %0d", retire_cnt, exp_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_again: got %b want 1", in_ready); end
        step();
        idle();
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (rf_wr_data !== 16'h3333) begin errors++; $display("FAIL bp_order3: got %h want 3333", rf_wr_data); end
        checks++; if (rf_wr_addr !== 3'd3) begin errors++; $display("FAIL bp_addr3: got %0d want 3", rf_wr_addr); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL bp_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
        step();
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", rf_valid); end
    endtask

`ifdef WB_FWD_EN
    task automatic test_fwd();
        rf_ready = 1'b0;
        fwd_addr = 3'd3;
        offer(2'b00, 16'h0000, 16'h0000, 16'h0011, 1'b0, 1'b1, 3'd3);
        #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_no_input: got %b want 0", fwd_hit); end
        step();
        offer(2'b00, 16'h0000, 16'h0000, 16'h0022, 1'b0, 1'b1, 3'd3);
        checks++; if (fwd_data !== 16'h0011) begin errors++; $display("FAIL fwd_first: got %h want 0011", fwd_data); end
        step();
        idle();
        exp_cnt = exp_cnt + 16'd2;
        checks++; if (fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit: got %b want 1", fwd_hit); end
        checks++; if (fwd_data !== 16'h0022) begin errors++; $display("FAIL fwd_young: got %h want 0022", fwd_data); end
        fwd_addr = 3'd5;
        #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss: got %b want 0", fwd_hit); end
        fwd_addr = 3'd3;
        rf_ready = 1'b1;
        step();
        rf_ready = 1'b0;
        checks++; if (fwd_data !== 16'h0022) begin errors++; $display("FAIL fwd_after_pop: got %h want 0022", fwd_data); end
        rf_ready = 1'b1;
        step();
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_empty: got %b want 0", fwd_hit); end
    endtask
`endif

    task automatic test_mid_reset();
        rf_ready = 1'b0;
        offer(2'b00, 16'h0000, 16'h0000, 16'h5555, 1'b0, 1'b1, 3'd6);
        step();
        offer(2'b00, 16'h0000, 16'h0000, 16'h6666, 1'b0, 1'b1, 3'd1);
        step();
        idle();
        checks++; if (rf_valid !== 1'b1) begin errors++; $display("FAIL mr_queued: got %b want 1", rf_valid); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b want 0", rf_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mr_ready: got %b want 0", in_ready); end
        checks++; if (rf_wr_data !== 16'h0000) begin errors++; $display("FAIL mr_data: got %h want 0000", rf_wr_data); end
        checks++; if (retire_cnt !== 16'd0) begin errors++; $display("FAIL mr_cnt: got %0d want 0", retire_cnt); end
        step();
        #2 rst_n = 1'b1;
        step();
        exp_cnt = 16'd0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_rel_ready: got %b want 1", in_ready); end
        rf_ready = 1'b1;
        step();
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL mr_discarded: got %b want 0", rf_valid); end
        checks++; if (retire_cnt !== 16'd0) begin errors++; $display("FAIL mr_rel_cnt: got %0d want 0", retire_cnt); end
    endtask

    task automatic test_wrap();
        int n;
        rf_ready = 1'b1;
        n = 65535 - int'(exp_cnt);
        offer(2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0);
        repeat (n) step();
        checks++; if (retire_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h want ffff", retire_cnt); end
        step();
        idle();
        checks++; if (retire_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", retire_cnt); end
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid: got %b want 0", rf_valid); end
    endtask

    initial begin
        rst_n    = 1'b0;
        rf_ready = 1'b0;
        exp_cnt  = 16'd0;
        idle();
`ifdef WB_FWD_EN
        fwd_addr = 3'd0;
`endif
        test_reset();
        test_no_write();
        test_pc_select();
        test_back_to_back();
        test_backpressure();
`ifdef WB_FWD_EN
        test_fwd();
`endif
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
